score_timer: RTL and testbench
==============================

Name: score_timer

Overview:
- Game bookkeeping stage for whack-a-mole.
- Holds a BCD countdown timer, a BCD miss counter and a BCD hit score.
- Presents them as eight BCD digits that feed the 8-digit seven-segment display driver directly, one digit per display input.
- Sits between the mole/button logic, which produces hit and miss pulses, and the display driver.

Parameters:
- TICKS_PER_SEC, 100000000: clk cycles per game second. Legal range is 2 or more.
- GAME_SECONDS, 60: game length in seconds. Legal range is 1..99. It is converted to two BCD digits at elaboration.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse that begins a new game
- hit  input  1  one-cycle pulse, one successful whack
- miss  input  1  one-cycle pulse, one missed mole
- display7  output  4  timer tens digit
- display6  output  4  timer units digit
- display5  output  4  misses tens digit
- display4  output  4  misses units digit
- display3  output  4  score thousands digit
- display2  output  4  score hundreds digit
- display1  output  4  score tens digit
- display0  output  4  score units digit
- running  output  1  high while state is RUN
- game_over  output  1  high while state is OVER

Behaviour:
- The design uses one clock domain. Reset is asynchronous and active-low (rst_n). All state and outputs are registered.
- Reset values:
  - state is IDLE
  - display7/6 hold GAME_SECONDS in BCD
  - display5..0 are 0
  - the prescaler is 0
  - running and game_over are 0
- States:
  - IDLE -> RUN on start.
  - RUN -> OVER on the second tick that makes the timer 00.
  - OVER -> RUN on start.
  - There are no other transitions.
- start in IDLE or OVER:
  - On the next edge the timer loads GAME_SECONDS in BCD, score and misses clear to 0, the prescaler clears to 0, and state becomes RUN.
  - start while in RUN is ignored.
- Prescaler:
  - Counts only in RUN, from 0 to TICKS_PER_SEC-1, then wraps to 0.
  - The wrap cycle is the second tick.
  - The first tick occurs TICKS_PER_SEC cycles after entering RUN.
- Timer:
  - On each second tick in RUN it decrements in BCD with borrow (10 -> 09, 01 -> 00).
  - When the decrement yields 00, state becomes OVER on the same edge. The timer stays at 00 until the next start.
- Score:
  - On a hit in RUN it increments as a 4-digit BCD value with carry (0099 -> 0100, 0999 -> 1000).
  - It saturates at 9999; further hits leave it unchanged.
- Misses:
  - On a miss in RUN it increments as a 2-digit BCD value and saturates at 99.
- Latency: digit outputs reflect a hit, miss or tick one clk after the sampled pulse.
- Simultaneous events:
  - hit and miss in the same cycle are both counted.
  - A hit or miss on the same cycle as the final tick (timer to 00) is counted, because the state is still RUN when it is sampled.
  - start together with hit in IDLE or OVER gives a score of 0; start takes priority.
- hit and miss outside RUN are ignored.
- Every digit output is always in the range 0..9.
- Reset mid-game: returns to reset values immediately, independent of clk.

Optional Feature:
- Macro: SCORE_TIMER_PAUSE_EN.
- When defined:
  - An extra input `pause`, 1 bit, level-sensitive, is added.
  - While pause is high in RUN, the prescaler and timer freeze, hit and miss are ignored, and running stays 1.
  - When pause goes low, counting resumes from the frozen prescaler value.
  - pause has no effect in IDLE or OVER.
- When undefined: the port is absent and behaviour is exactly as described above.

Test Plan:
- Reset, then release with TICKS_PER_SEC=10, GAME_SECONDS=3 -> displays read 3,0? No: display7=0, display6=3, display5..0=0, running=0, game_over=0.
- start pulse, then no input -> running=1 the next cycle; timer reads 02 after 10 cycles, 01 after 20, 00 after 30; at that edge running=0 and game_over=1.
- In RUN, 100 hit pulses and 3 miss pulses, with 2 cycles each carrying both hit and miss -> score digits 0,1,0,0 and misses 0,3.
- Preload the score by 9999 hits (GAME_SECONDS=99, large TICKS_PER_SEC), then 5 more hits -> score stays 9,9,9,9; 120 misses -> misses stay 9,9.
- hit on the final-tick cycle -> counted and game_over=1. Then hits in OVER -> unchanged. Then start with hit -> score 0, timer 03, running=1.
- Assert rst_n low mid-game, asynchronously between clk edges -> outputs return to reset values before the next edge. With SCORE_TIMER_PAUSE_EN: pause held 25 cycles mid-second -> the timer decrement is delayed by exactly 25 cycles and hits are ignored during the pause.

Source files
------------

// File: rtl/score_timer.sv
// Whack-a-mole bookkeeping: BCD countdown timer, BCD miss counter and BCD hit score as eight display digits.
// Digits update one clk after a sampled pulse; no backpressure. Optional pause input under SCORE_TIMER_PAUSE_EN.
module score_timer #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int GAME_SECONDS  = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
`ifdef SCORE_TIMER_PAUSE_EN
  input  logic       pause,
`endif
  output logic [3:0] display7,
  output logic [3:0] display6,
  output logic [3:0] display5,
  output logic [3:0] display4,
  output logic [3:0] display3,
  output logic [3:0] display2,
  output logic [3:0] display1,
  output logic [3:0] display0,
  output logic       running,
  output logic       game_over
);

  localparam int              PW        = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]      GS_BCD    = {4'(GAME_SECONDS / 10), 4'(GAME_SECONDS % 10)};

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_OVER} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_running;
  logic            r_game_over;
  logic            w_running_nxt;
  logic            w_over_nxt;
  logic [PW-1:0]   r_presc;
  logic [7:0]      r_tmr;
  logic [7:0]      r_miss;
  logic [15:0]     r_score;

  logic            w_pause;
  logic            w_active;
  logic            w_tick;
  logic            w_last;
  logic            w_load;
  logic [7:0]      w_tmr_dec;
  logic [7:0]      w_miss_inc;
  logic [15:0]     w_score_inc;

`ifdef SCORE_TIMER_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_active = (r_state == ST_RUN) && !w_pause;
  assign w_tick   = w_active && (r_presc == PRESC_MAX);
  assign w_last   = w_tick && (r_tmr == 8'h01);
  assign w_load   = start && (r_state != ST_RUN);

  // Timer never sits at 00 while running, so the tens borrow cannot underflow.
  assign w_tmr_dec = (r_tmr[3:0] == 4'd0) ? {r_tmr[7:4] - 4'd1, 4'd9}
                                          : {r_tmr[7:4], r_tmr[3:0] - 4'd1};

  assign w_miss_inc = (r_miss == 8'h99)      ? r_miss :
                      (r_miss[3:0] == 4'd9)  ? {r_miss[7:4] + 4'd1, 4'd0} :
                                               {r_miss[7:4], r_miss[3:0] + 4'd1};

  function automatic logic [15:0] bcd4_inc_sat(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = (v != 16'h9999);
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign w_score_inc = bcd4_inc_sat(r_score);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_running   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_running   <= w_running_nxt;
      r_game_over <= w_over_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_OVER: if (start)  w_state_nxt = ST_RUN;
      ST_RUN:           if (w_last) w_state_nxt = ST_OVER;
      default:                      w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_running_nxt = (w_state_nxt == ST_RUN);
    w_over_nxt    = (w_state_nxt == ST_OVER);
  end

  // start outranks hit/miss because load is only possible outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_tmr   <= GS_BCD;
      r_miss  <= '0;
      r_score <= '0;
    end else if (w_load) begin
      r_presc <= '0;
      r_tmr   <= GS_BCD;
      r_miss  <= '0;
      r_score <= '0;
    end else if (w_active) begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) r_tmr   <= w_tmr_dec;
      if (hit)    r_score <= w_score_inc;
      if (miss)   r_miss  <= w_miss_inc;
    end
  end

  assign display7  = r_tmr[7:4];
  assign display6  = r_tmr[3:0];
  assign display5  = r_miss[7:4];
  assign display4  = r_miss[3:0];
  assign display3  = r_score[15:12];
  assign display2  = r_score[11:8];
  assign display1  = r_score[7:4];
  assign display0  = r_score[3:0];
  assign running   = r_running;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_score_timer.sv
// Two score_timer instances (short game, long game) checked every cycle against an integer game model.
module tb_score_timer;

  localparam int TA = 10;
  localparam int GA = 3;
  localparam int TB = 200;
  localparam int GB = 99;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] st, ht, ms, pz;
  logic [3:0] da [8];
  logic [3:0] db [8];
  logic [1:0] run_o, ovr_o;

  always #5 clk = ~clk;

  score_timer #(.TICKS_PER_SEC(TA), .GAME_SECONDS(GA)) u_a (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .hit(ht[0]), .miss(ms[0]),
`ifdef SCORE_TIMER_PAUSE_EN
    .pause(pz[0]),
`endif
    .display7(da[7]), .display6(da[6]), .display5(da[5]), .display4(da[4]),
    .display3(da[3]), .display2(da[2]), .display1(da[1]), .display0(da[0]),
    .running(run_o[0]), .game_over(ovr_o[0])
  );

  score_timer #(.TICKS_PER_SEC(TB), .GAME_SECONDS(GB)) u_b (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .hit(ht[1]), .miss(ms[1]),
`ifdef SCORE_TIMER_PAUSE_EN
    .pause(pz[1]),
`endif
    .display7(db[7]), .display6(db[6]), .display5(db[5]), .display4(db[4]),
    .display3(db[3]), .display2(db[2]), .display1(db[1]), .display0(db[0]),
    .running(run_o[1]), .game_over(ovr_o[1])
  );

  int n_chk, n_fail;

  // Game model: 0 idle, 1 running, 2 over; seconds left and cycles into the current second.
  int tps  [2] = '{TA, TB};
  int gsec [2] = '{GA, GB};
  int m_state [2];
  int m_sec   [2];
  int m_ph    [2];
  int m_score [2];
  int m_miss  [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = 0; m_sec[d] = gsec[d]; m_ph[d] = 0; m_score[d] = 0; m_miss[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input logic s, input logic h, input logic m, input logic p);
    if (m_state[d] != 1) begin
      if (s) begin
        m_state[d] = 1; m_sec[d] = gsec[d]; m_ph[d] = 0; m_score[d] = 0; m_miss[d] = 0;
      end
    end else if (!p) begin
      if (h && m_score[d] < 9999) m_score[d]++;
      if (m && m_miss[d] < 99)    m_miss[d]++;
      if (m_ph[d] == tps[d] - 1) begin
        m_ph[d] = 0;
        m_sec[d]--;
        if (m_sec[d] == 0) m_state[d] = 2;
      end else begin
        m_ph[d]++;
      end
    end
  endtask

  task automatic expect_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check(input int d, input string tag);
    logic [31:0] obs, exp;
    logic [1:0]  fo, fe;
    if (d == 0) begin
      obs = {da[7], da[6], da[5], da[4], da[3], da[2], da[1], da[0]};
      fo  = {run_o[0], ovr_o[0]};
    end else begin
      obs = {db[7], db[6], db[5], db[4], db[3], db[2], db[1], db[0]};
      fo  = {run_o[1], ovr_o[1]};
    end
    exp = {4'(m_sec[d] / 10), 4'(m_sec[d] % 10), 4'(m_miss[d] / 10), 4'(m_miss[d] % 10),
           4'(m_score[d] / 1000), 4'((m_score[d] / 100) % 10), 4'((m_score[d] / 10) % 10),
           4'(m_score[d] % 10)};
    fe = {m_state[d] == 1, m_state[d] == 2};
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s digits dut%0d: got %h want %h", tag, d, obs, exp);
    end
    n_chk++;
    assert (fo === fe) else begin
      n_fail++;
      $error("FAIL %s flags dut%0d: got %b want %b", tag, d, fo, fe);
    end
  endtask

  // One clock: drive pulses, let the edge sample them, step the model, then compare both DUTs.
  task automatic cyc(input logic [1:0] s, input logic [1:0] h, input logic [1:0] m, input logic [1:0] p);
    logic [1:0] pe;
`ifdef SCORE_TIMER_PAUSE_EN
    pe = p;
`else
    pe = 2'b00 & p;
`endif
    st = s; ht = h; ms = m; pz = pe;
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_step(d, s[d], h[d], m[d], pe[d]);
    #1;
    st = '0; ht = '0; ms = '0;
    check(0, "cyc");
    check(1, "cyc");
  endtask

  // Directed pulses to DUT B with random traffic on DUT A.
  task automatic cycb(input logic s, input logic h, input logic m);
    logic ra_s, ra_h, ra_m, ra_p;
    ra_s = ($urandom_range(0, 15) == 0);
    ra_h = ($urandom_range(0, 1) == 0);
    ra_m = ($urandom_range(0, 2) == 0);
    ra_p = ($urandom_range(0, 3) == 0);
    cyc({s, ra_s}, {h, ra_h}, {m, ra_m}, {1'b0, ra_p});
  endtask

  initial begin
    int k;
    n_chk = 0; n_fail = 0;
    st = '0; ht = '0; ms = '0; pz = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check(0, "reset");
    check(1, "reset");
    expect_v("reset_timer_a", {24'h0, da[7], da[6]}, 32'h03);
    @(negedge clk) rst_n = 1'b1;

    // Idle: hit/miss ignored.
    cyc(2'b00, 2'b11, 2'b11, 2'b00);
    cyc(2'b00, 2'b00, 2'b00, 2'b00);

    // Full short game without input.
    cyc(2'b01, 2'b00, 2'b00, 2'b00);
    expect_v("run_after_start", {31'h0, run_o[0]}, 32'h1);
    for (int i = 1; i <= 30; i++) begin
      cyc(2'b01 & {1'b0, i == 5}, 2'b00, 2'b00, 2'b00);
      if (i == 10) expect_v("timer_02", {24'h0, da[7], da[6]}, 32'h02);
      if (i == 20) expect_v("timer_01", {24'h0, da[7], da[6]}, 32'h01);
    end
    expect_v("timer_00", {24'h0, da[7], da[6]}, 32'h00);
    expect_v("over_flags", {30'h0, run_o[0], ovr_o[0]}, 32'h1);

    // Hit on the final-tick cycle, then hits in OVER, then start+hit.
    cyc(2'b01, 2'b00, 2'b00, 2'b00);
    for (int i = 1; i <= 29; i++) cyc(2'b00, 2'b00, 2'b00, 2'b00);
    cyc(2'b00, 2'b01, 2'b00, 2'b00);
    expect_v("final_tick_hit", {16'h0, da[3], da[2], da[1], da[0]}, 32'h0001);
    expect_v("final_tick_over", {31'h0, ovr_o[0]}, 32'h1);
    for (int i = 0; i < 3; i++) cyc(2'b00, 2'b01, 2'b01, 2'b00);
    expect_v("over_hits_ignored", {16'h0, da[3], da[2], da[1], da[0]}, 32'h0001);
    cyc(2'b01, 2'b01, 2'b00, 2'b00);
    expect_v("start_hit_score", {16'h0, da[3], da[2], da[1], da[0]}, 32'h0000);
    expect_v("start_hit_timer", {24'h0, da[7], da[6]}, 32'h03);
    expect_v("start_hit_run", {31'h0, run_o[0]}, 32'h1);

    // Long game on B: 100 hits, 3 misses (two coincide with hits), then saturation.
    cycb(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) cycb(1'b0, 1'b1, (i == 10) || (i == 50));
    cycb(1'b0, 1'b0, 1'b1);
    expect_v("score_0100", {16'h0, db[3], db[2], db[1], db[0]}, 32'h0100);
    expect_v("misses_03", {24'h0, db[5], db[4]}, 32'h03);
    for (int i = 0; i < 9899; i++) cycb(1'b0, 1'b1, 1'b0);
    expect_v("score_9999", {16'h0, db[3], db[2], db[1], db[0]}, 32'h9999);
    for (int i = 0; i < 5; i++) cycb(1'b0, 1'b1, 1'b0);
    expect_v("score_sat", {16'h0, db[3], db[2], db[1], db[0]}, 32'h9999);
    for (int i = 0; i < 120; i++) cycb(1'b0, 1'b0, 1'b1);
    expect_v("misses_sat", {24'h0, db[5], db[4]}, 32'h99);
    k = 0;
    while (m_state[1] == 1 && k < 20000) begin
      cycb(1'b0, 1'b0, 1'b0);
      k++;
    end
    expect_v("b_over", {30'h0, run_o[1], ovr_o[1]}, 32'h1);
    expect_v("b_timer_00", {24'h0, db[7], db[6]}, 32'h00);

    // Asynchronous reset between edges.
    cyc(2'b11, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 15; i++) cyc(2'b00, 2'b11, 2'b10, 2'b00);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check(0, "async_reset");
    check(1, "async_reset");
    @(negedge clk) rst_n = 1'b1;
    cyc(2'b00, 2'b00, 2'b00, 2'b00);

`ifdef SCORE_TIMER_PAUSE_EN
    // Pause for 25 cycles mid-second: tick moves from cycle 10 to cycle 35.
    cyc(2'b01, 2'b00, 2'b00, 2'b00);
    for (int i = 1; i <= 4; i++) cyc(2'b00, 2'b00, 2'b00, 2'b00);
    for (int i = 5; i <= 29; i++) cyc(2'b00, 2'b01, 2'b01, 2'b01);
    expect_v("pause_hits_ignored", {16'h0, da[3], da[2], da[1], da[0]}, 32'h0000);
    expect_v("pause_running", {31'h0, run_o[0]}, 32'h1);
    k = 0;
    for (int i = 30; i <= 60; i++) begin
      cyc(2'b00, 2'b00, 2'b00, 2'b00);
      if (k == 0 && da[6] == 4'd2) k = i;
    end
    expect_v("pause_tick_cycle", k, 32'd35);
`endif

    // Random traffic on both DUTs.
    cyc(2'b11, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 2000; i++)
      cyc({1'b0, $urandom_range(0, 31) == 0}, 2'($urandom), 2'($urandom), {1'b0, $urandom_range(0, 3) == 0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
